// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush enables, RAW forwarding, memory-wait FSM.
// Optional stall counter built when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic                 MemReqM,
  input  logic                 mem_ready,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteW,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 StallEM,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] TMO_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_e;

  state_e          state_q;
  logic [WW-1:0]   wait_cnt_q;
  logic            mem_err_q;

  logic            timeout;
  logic            memstall;
  logic            lwstall;
  logic            branch;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs)
      return 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Timeout cycle releases the pipe so the abandoned access drains.
  always_comb begin
    timeout  = (state_q == MEM_WAIT) &&
               (wait_cnt_q == TMO_LAST) && !mem_ready;
    memstall = 1'b0;
    unique case (state_q)
      IDLE:     memstall = MemReqM && !mem_ready;
      MEM_WAIT: memstall = !mem_ready && !timeout;
      default:  memstall = 1'b0;
    endcase
    lwstall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
              ((RdE == Rs1D) || (RdE == Rs2D));
    branch  = PCSrcE;
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    StallEM   = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if (memstall) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallEM = 1'b1;
        FlushW  = 1'b1;
      end else begin
        StallF = lwstall;
        StallD = lwstall && !branch;
        FlushD = branch;
        FlushE = lwstall || branch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (MemReqM && !mem_ready)
            state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready || timeout) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            if (timeout)
              mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (StallF)
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed sequences, random vs model.
// Timeout behaviour exercised with MEM_TIMEOUT=4.
module tb_hazard_ctrl;

  localparam int T  = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, RegWriteM, MemReqM, mem_ready, RegWriteW;
  logic          StallF, StallD, FlushD, FlushE, StallEM, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          mem_err;
  logic [CW-1:0] stall_cycles;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM),
    .mem_ready(mem_ready), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .StallEM(StallEM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_wait;
  int          m_n;
  bit          m_err;
  logic [CW-1:0] m_cnt;
  bit          e_ms;
  logic        e_sf, e_sd, e_fd, e_fe, e_sem, e_fw;
  logic [1:0]  e_fa, e_fb;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit lw;
    lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (!m_wait) e_ms = MemReqM && !mem_ready;
    else         e_ms = !mem_ready && (m_n < T);
    {e_sf, e_sd, e_fd, e_fe, e_sem, e_fw} = '0;
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (rst) begin
      {e_fd, e_fe, e_fw} = 3'b111;
    end else begin
      e_fa = mfwd(Rs1E);
      e_fb = mfwd(Rs2E);
      if (e_ms) begin
        {e_sf, e_sd, e_sem, e_fw} = 4'b1111;
      end else begin
        e_sf = lw;
        e_sd = lw && !PCSrcE;
        e_fd = PCSrcE;
        e_fe = lw || PCSrcE;
      end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_wait = 0; m_n = 0; m_err = 0; m_cnt = '0;
    end else begin
      if (e_sf) m_cnt = m_cnt + 1;
      if (!m_wait) begin
        if (e_ms) begin m_wait = 1; m_n = 1; end
      end else if (mem_ready) begin
        m_wait = 0;
      end else if (m_n == T) begin
        m_wait = 0; m_err = 1;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    check("StallF", 32'(StallF), 32'(e_sf));
    check("StallD", 32'(StallD), 32'(e_sd));
    check("FlushD", 32'(FlushD), 32'(e_fd));
    check("FlushE", 32'(FlushE), 32'(e_fe));
    check("StallEM", 32'(StallEM), 32'(e_sem));
    check("FlushW", 32'(FlushW), 32'(e_fw));
    check("ForwardAE", 32'(ForwardAE), 32'(e_fa));
    check("ForwardBE", 32'(ForwardBE), 32'(e_fb));
    check("mem_err", 32'(mem_err), 32'(m_err));
`ifdef HAZARD_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_cnt);
`else
    check("stall_cycles", stall_cycles, 32'd0);
`endif
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, MemReqM, RegWriteW} = '0;
    mem_ready = 1'b0;
  endtask

  typedef struct {
    logic [4:0] r1d, r2d, r1e, r2e, rde, rdm, rdw;
    logic [1:0] rs;
    logic       pc, wm, ww;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // r1d r2d r1e r2e rde rdm rdw rs pc wm ww | fa fb sf sd fd fe
    tbl[0]  = '{0,0,5,0,0,5,0,2'b00,0,1,0, 2'b10,2'b00,0,0,0,0};
    tbl[1]  = '{0,0,5,0,0,0,5,2'b00,0,0,1, 2'b01,2'b00,0,0,0,0};
    tbl[2]  = '{0,0,0,0,0,0,0,2'b00,0,1,1, 2'b00,2'b00,0,0,0,0};
    tbl[3]  = '{0,0,0,7,0,7,7,2'b00,0,1,1, 2'b00,2'b10,0,0,0,0};
    tbl[4]  = '{0,0,0,9,0,0,9,2'b00,0,0,1, 2'b00,2'b01,0,0,0,0};
    tbl[5]  = '{0,0,9,9,0,9,9,2'b00,0,0,0, 2'b00,2'b00,0,0,0,0};
    tbl[6]  = '{5,0,0,0,5,0,0,2'b01,0,0,0, 2'b00,2'b00,1,1,0,1};
    tbl[7]  = '{0,0,0,0,0,0,0,2'b01,0,0,0, 2'b00,2'b00,0,0,0,0};
    tbl[8]  = '{0,5,0,0,5,0,0,2'b00,0,0,0, 2'b00,2'b00,0,0,0,0};
    tbl[9]  = '{3,6,0,0,6,0,0,2'b01,0,0,0, 2'b00,2'b00,1,1,0,1};
    tbl[10] = '{0,0,0,0,0,0,0,2'b00,1,0,0, 2'b00,2'b00,0,0,1,1};
    tbl[11] = '{5,0,0,0,5,0,0,2'b01,1,0,0, 2'b00,2'b00,1,0,1,1};

    m_wait = 0; m_n = 0; m_err = 0; m_cnt = '0;
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    sample();
    check("rst_FlushD", 32'(FlushD), 32'd1);
    check("rst_StallF", 32'(StallF), 32'd0);
    check("rst_memerr", 32'(mem_err), 32'd0);
    advance();
    rst = 1'b0;

    foreach (tbl[i]) begin
      clr();
      Rs1D = tbl[i].r1d; Rs2D = tbl[i].r2d;
      Rs1E = tbl[i].r1e; Rs2E = tbl[i].r2e;
      RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
      ResultSrcE = tbl[i].rs; PCSrcE = tbl[i].pc;
      RegWriteM = tbl[i].wm; RegWriteW = tbl[i].ww;
      mem_ready = 1'b1;
      sample();
      check($sformatf("tbl%0d_fa", i), 32'(ForwardAE), 32'(tbl[i].fa));
      check($sformatf("tbl%0d_fb", i), 32'(ForwardBE), 32'(tbl[i].fb));
      check($sformatf("tbl%0d_sf", i), 32'(StallF), 32'(tbl[i].sf));
      check($sformatf("tbl%0d_sd", i), 32'(StallD), 32'(tbl[i].sd));
      check($sformatf("tbl%0d_fd", i), 32'(FlushD), 32'(tbl[i].fd));
      check($sformatf("tbl%0d_fe", i), 32'(FlushE), 32'(tbl[i].fe));
      advance();
    end

    // load-use: one stall cycle then W forwarding
    clr(); mem_ready = 1'b1;
    ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
    sample(); check("lu_stall", 32'(StallF), 32'd1); advance();
    clr(); mem_ready = 1'b1; Rs1D = 5; RdM = 5; RegWriteM = 1;
    sample(); check("lu_release", 32'(StallF), 32'd0); advance();
    clr(); mem_ready = 1'b1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    sample(); check("lu_fwd", 32'(ForwardAE), 32'd1); advance();

    // memory wait of 3 cycles
    clr(); MemReqM = 1;
    for (int c = 0; c < 3; c++) begin
      sample(); check("mw_stall", 32'(StallEM), 32'd1); advance();
    end
    mem_ready = 1;
    sample(); check("mw_ready", 32'(StallF), 32'd0); advance();

    // branch held during 2-cycle memstall
    clr(); MemReqM = 1; PCSrcE = 1;
    for (int c = 0; c < 2; c++) begin
      sample(); check("br_hold", 32'(FlushD), 32'd0); advance();
    end
    mem_ready = 1;
    sample(); check("br_rel_fd", 32'(FlushD), 32'd1);
    check("br_rel_fe", 32'(FlushE), 32'd1); advance();

    // timeout: T stall cycles then release with sticky error
    clr(); MemReqM = 1;
    for (int c = 0; c < T; c++) begin
      sample(); check("to_stall", 32'(StallF), 32'd1); advance();
    end
    sample(); check("to_release", 32'(StallF), 32'd0); advance();
    clr(); mem_ready = 1;
    sample(); check("to_err", 32'(mem_err), 32'd1); advance();
    tick();
    rst = 1; tick(); rst = 0;
    sample(); check("to_err_clr", 32'(mem_err), 32'd0); advance();

    // reset mid-wait
    clr(); MemReqM = 1; tick(); tick();
    rst = 1;
    sample(); check("rw_rst_fw", 32'(FlushW), 32'd1);
    check("rw_rst_sf", 32'(StallF), 32'd0); advance();
    rst = 0; MemReqM = 0;
    sample(); check("rw_idle", 32'(StallF), 32'd0);
    check("rw_noerr", 32'(mem_err), 32'd0); advance();

    // random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 4) == 0);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      MemReqM    = ($urandom_range(0, 2) == 0);
      mem_ready  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
